// File: rtl/audio_pwm_player.sv
// Purpose: buffers signed audio samples in a FIFO and replays them as PWM, one sample per SAMPLE_DIV clocks.
// Latency: a popped sample drives the duty from the next cycle; pwm_out follows counter/duty by one cycle.
// Backpressure: none upstream; a sample arriving at a full FIFO with no pop that cycle is dropped and flagged.
module audio_pwm_player #(
  parameter int SAMPLE_DIV  = 1024,
  parameter int PWM_BITS    = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                          clk_25mhz,
  input  logic                          reset_n,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_valid,
  input  logic                          enable,
  input  logic                          flags_clear,
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          playing,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [PWM_BITS-1:0] DUTY_MID  = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]    PRIME_CNT = CNT_W'(PRIME_LEVEL);
  localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_PLAY} state_e;

  state_e                state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic                  pwm_q, pwm_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  // Sample FIFO storage and bookkeeping
  logic [15:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  fifo_full, fifo_empty;
  logic                  fifo_push, fifo_pop, fifo_flush;
  logic [15:0]           fifo_head;
  logic                  start_play, sample_tick;
  logic                  ovf_set, unf_set;

  // Offset-binary conversion: flip the sign bit and keep the top PWM_BITS bits.
  function automatic logic [PWM_BITS-1:0] to_duty(input logic [15:0] s);
    logic [15:0] ob;
    ob = {~s[15], s[14:0]};
    return ob[15 -: PWM_BITS];
  endfunction

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign pwm_out    = pwm_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

  // Pop/push/flush decisions; disabling the player flushes and suppresses all traffic.
  always_comb begin
    start_play  = (state_q == ST_PRIME) && (count_q >= PRIME_CNT);
    sample_tick = (state_q == ST_PLAY) && (tick_q == TICK_LAST);
    fifo_flush  = !enable;
    fifo_pop    = enable && !fifo_empty && (start_play || sample_tick);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    fifo_push   = enable && sample_valid && (!fifo_full || fifo_pop);
    ovf_set     = enable && sample_valid && fifo_full && !fifo_pop;
    unf_set     = enable && sample_tick && fifo_empty;
  end

  // FIFO pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (fifo_push && !fifo_pop)      count_d = count_q + CNT_W'(1);
      else if (fifo_pop && !fifo_push) count_d = count_q - CNT_W'(1);
    end
  end

  // FSM next state: enable low always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: if (start_play) state_d = ST_PLAY;
        ST_PLAY:  if (sample_tick && fifo_empty) state_d = ST_PRIME;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    playing = (state_q == ST_PLAY);
  end

  // Tick/duty/PWM/flag next state
  always_comb begin
    // The counter is zeroed when playback is abandoned, then free-runs in IDLE
    // so the idle output is still a midscale square wave.
    if (!enable && state_q != ST_IDLE) tick_d = '0;
    else if (start_play)               tick_d = '0;
    else if (tick_q == TICK_LAST)      tick_d = '0;
    else                               tick_d = tick_q + TICK_W'(1);

    if (!enable)       duty_d = DUTY_MID;
    else if (fifo_pop) duty_d = to_duty(fifo_head);
    else if (unf_set)  duty_d = DUTY_MID;
    else               duty_d = duty_q;

    pwm_d = (tick_q[PWM_BITS-1:0] < duty_q);

    // A set event in the same cycle beats a clear request.
    if (ovf_set)          ovf_d = 1'b1;
    else if (flags_clear) ovf_d = 1'b0;
    else                  ovf_d = ovf_q;

    if (unf_set)          unf_d = 1'b1;
    else if (flags_clear) unf_d = 1'b0;
    else                  unf_d = unf_q;
  end

  // State register and all resettable control/datapath registers
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      duty_q   <= DUTY_MID;
      pwm_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write; contents need no reset because occupancy gates every read
  always_ff @(posedge clk_25mhz) begin
    if (fifo_push) mem_q[wr_ptr_q] <= sample_in;
  end

endmodule

// File: tb/tb_audio_pwm_player.sv
// Purpose: directed bench for audio_pwm_player with a duty scoreboard fed at stimulus time.
// Latency: the monitor scores each played sample over one full sample period of pwm_out.
// Backpressure: none; overflow/underflow and flush paths are driven explicitly.
module tb_audio_pwm_player;

  localparam int SAMPLE_DIV  = 1024;
  localparam int PWM_BITS    = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int PRIME_LEVEL = 8;
  localparam int HI_PER_DUTY = SAMPLE_DIV / (1 << PWM_BITS);

  logic        clk_25mhz    = 1'b0;
  logic        reset_n      = 1'b0;
  logic [15:0] sample_in    = '0;
  logic        sample_valid = 1'b0;
  logic        enable       = 1'b0;
  logic        flags_clear  = 1'b0;
  logic        pwm_out;
  logic [4:0]  fifo_count;
  logic        playing;
  logic        overflow;
  logic        underflow;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  int          exp_q[$];

  audio_pwm_player #(
    .SAMPLE_DIV  (SAMPLE_DIV),
    .PWM_BITS    (PWM_BITS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .PRIME_LEVEL (PRIME_LEVEL)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .enable       (enable),
    .flags_clear  (flags_clear),
    .pwm_out      (pwm_out),
    .fifo_count   (fifo_count),
    .playing      (playing),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #20 clk_25mhz = ~clk_25mhz;
  always @(posedge clk_25mhz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input int req);
    checks++;
    if (act !== 32'(req)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_25mhz);
    #1;
  endtask

  // One-cycle push; the expected duty is queued when the sample should eventually play.
  task automatic push(input logic [15:0] s, input int duty, input bit will_play);
    sample_valid = 1'b1;
    sample_in    = s;
    if (will_play) exp_q.push_back(duty);
    next_cycle();
    sample_valid = 1'b0;
  endtask

  // Monitor: each PLAY sample period yields 1024 pwm_out values whose high count is 4*duty.
  int mon_hi     = 0;
  int mon_n      = 0;
  bit mon_active = 1'b0;
  always @(negedge clk_25mhz) begin
    int d;
    if (mon_active) begin
      if (pwm_out === 1'b1) mon_hi++;
      mon_n++;
      if (mon_n == SAMPLE_DIV) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_window: sample period played with nothing expected, high=%0d", mon_hi);
        end else begin
          d = exp_q.pop_front();
          check("sb_window_high", mon_hi, d * HI_PER_DUTY);
        end
        mon_hi = 0;
        mon_n  = 0;
      end
    end
    if (playing !== 1'b1) begin
      mon_hi = 0;
      mon_n  = 0;
    end
    mon_active = (playing === 1'b1);
  end

  logic [15:0] fill_s [7] = '{16'h4000, 16'hC000, 16'h1234, 16'hFF80, 16'h0100, 16'h80FF, 16'h7F00};
  int          fill_d [7] = '{192, 64, 146, 127, 129, 0, 255};

  initial begin
    int start;
    int hi;
    int n;

    // Reset state
    repeat (3) @(posedge clk_25mhz);
    #1;
    check("rst_fifo_count", fifo_count, 0);
    check("rst_playing", playing, 0);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    reset_n = 1'b1;
    next_cycle();
    enable = 1'b1;
    repeat (3) next_cycle();

    // Priming with full-scale positive samples
    for (int i = 0; i < PRIME_LEVEL - 1; i++) push(16'h7FFF, 255, 1'b1);
    check("prime_count7", fifo_count, 7);
    check("prime_not_playing", playing, 0);
    push(16'h7FFF, 255, 1'b1);
    check("prime_count8", fifo_count, 8);
    check("prime_still_prime", playing, 0);
    next_cycle();
    check("play_entered", playing, 1);
    check("play_first_pop", fifo_count, 7);
    start = cyc;

    // Extremes, fillers up to full, then one dropped sample
    push(16'h8000, 0, 1'b1);
    push(16'h0000, 128, 1'b1);
    for (int i = 0; i < 7; i++) push(fill_s[i], fill_d[i], 1'b1);
    check("fill_count16", fifo_count, 16);
    check("fill_no_overflow", overflow, 0);
    push(16'h5555, 0, 1'b0);
    check("drop_count16", fifo_count, 16);
    check("drop_overflow", overflow, 1);
    flags_clear = 1'b1;
    next_cycle();
    flags_clear = 1'b0;
    check("clear_overflow", overflow, 0);

    // Push coinciding with the sample tick while full
    while (cyc < start + SAMPLE_DIV - 1) next_cycle();
    push(16'hA5A5, 37, 1'b1);
    check("tick_push_count16", fifo_count, 16);
    check("tick_push_no_overflow", overflow, 0);

    // Drain until underflow
    n = 0;
    while (playing === 1'b1 && n < 20000) begin
      next_cycle();
      n++;
    end
    check("uf_playing", playing, 0);
    check("uf_flag", underflow, 1);
    check("uf_fifo_empty", fifo_count, 0);
    repeat (2) next_cycle();
    check("sb_all_played", exp_q.size(), 0);
    hi = 0;
    repeat (4) next_cycle();
    for (int i = 0; i < 256; i++) begin
      next_cycle();
      if (pwm_out === 1'b1) hi++;
    end
    check("uf_pwm_midscale", hi, 128);
    check("uf_sticky", underflow, 1);
    flags_clear = 1'b1;
    next_cycle();
    flags_clear = 1'b0;
    check("clear_underflow", underflow, 0);

    // Asynchronous reset in the middle of playback
    for (int i = 0; i < PRIME_LEVEL; i++) push(16'h7FFF, 0, 1'b0);
    next_cycle();
    check("rst_test_playing", playing, 1);
    check("rst_test_count", fifo_count, 7);
    repeat (50) next_cycle();
    check("pre_reset_pwm", pwm_out, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count", fifo_count, 0);
    check("async_rst_pwm", pwm_out, 0);
    check("async_rst_playing", playing, 0);
    repeat (2) @(posedge clk_25mhz);
    #5;
    reset_n = 1'b1;
    next_cycle();
    check("post_rst_count", fifo_count, 0);
    check("post_rst_playing", playing, 0);

    // Restart from IDLE, play one sample, then disable to flush
    repeat (2) next_cycle();
    for (int i = 0; i < PRIME_LEVEL; i++) push(16'h0000, 128, 1'b1);
    n = 0;
    while (playing !== 1'b1 && n < 10) begin
      next_cycle();
      n++;
    end
    check("restart_playing", playing, 1);
    n = 0;
    while (exp_q.size() > 7 && n < 1200) begin
      next_cycle();
      n++;
    end
    check("restart_one_window", exp_q.size(), 7);
    enable = 1'b0;
    next_cycle();
    exp_q.delete();
    check("disable_playing", playing, 0);
    check("disable_flush", fifo_count, 0);
    push(16'h1234, 0, 1'b0);
    check("disabled_push_ignored", fifo_count, 0);
    check("disabled_no_overflow", overflow, 0);
    repeat (4) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_pwm_player.md
AUDIO_PWM_PLAYER -- requirements
Module: audio_pwm_player

Interface
REQ-001 Parameter: SAMPLE_DIV, 1024, clk_25mhz cycles per output sample; SHALL be a multiple of 2^PWM_BITS.
REQ-002 Parameter: PWM_BITS, 8, PWM duty resolution in bits; PWM period = 2^PWM_BITS cycles.
REQ-003 Parameter: FIFO_DEPTH, 16, sample FIFO entries; power of two.
REQ-004 Parameter: PRIME_LEVEL, 8, FIFO occupancy required before playback starts; 1..FIFO_DEPTH.
REQ-005 Port: clk_25mhz  in  1  sole clock, all logic on rising edge.
REQ-006 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port: sample_in  in  16  signed two's-complement audio sample from the SPI receiver.
REQ-008 Port: sample_valid  in  1  one-cycle strobe; sample_in valid this cycle.
REQ-009 Port: enable  in  1  playback enable; low flushes and idles.
REQ-010 Port: flags_clear  in  1  clears sticky overflow/underflow.
REQ-011 Port: pwm_out  out  1  registered PWM audio output.
REQ-012 Port: fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 Port: playing  out  1  high while state is PLAY.
REQ-014 Port: overflow  out  1  sticky: sample dropped on full FIFO.
REQ-015 Port: underflow  out  1  sticky: FIFO empty at a sample tick in PLAY.

Function
REQ-016 States SHALL be IDLE, PRIME, PLAY.
REQ-017 IDLE: enable=1 -> PRIME; enable=0 in any state -> IDLE next cycle, FIFO flushed (count 0), tick counter 0, duty = midscale 2^(PWM_BITS-1).
REQ-018 PRIME: when fifo_count >= PRIME_LEVEL -> PLAY; on that transition cycle one sample is popped, duty loaded, tick counter set 0.
REQ-019 PLAY: tick counter counts 0..SAMPLE_DIV-1 and wraps; at count SAMPLE_DIV-1 one sample is popped and duty loaded next cycle (aligned to PWM period start).
REQ-020 PLAY tick with FIFO empty: underflow set, duty = midscale, state -> PRIME.
REQ-021 Push: sample_valid=1 and FIFO not full -> sample written, any state except cycle where enable=0 (flush wins).
REQ-022 Push with FIFO full and no pop same cycle: sample dropped, overflow set, contents unchanged.
REQ-023 Push and pop same cycle: both performed, count unchanged, no overflow even when full; pop returns oldest entry.
REQ-024 FIFO SHALL be first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-025 Duty conversion: duty = {~sample[15], sample[14:16-PWM_BITS]} (offset binary of top PWM_BITS bits); lower bits discarded.
REQ-026 PWM counter = low PWM_BITS of tick counter; pwm_out registered as (pwm_cnt < duty), one-cycle latency; duty 0 -> constant low, duty max -> high 2^PWM_BITS-1 of 2^PWM_BITS cycles.
REQ-027 In IDLE and PRIME, PWM counter SHALL free-run and output midscale duty (50% square wave).
REQ-028 flags_clear=1 clears overflow and underflow; a set event in the same cycle wins.
REQ-029 playing = 1 exactly when state is PLAY.

Reset
REQ-030 reset_n=0 SHALL immediately force: state IDLE, FIFO empty, fifo_count 0, pointers 0, tick counter 0, duty midscale, pwm_out 0, playing 0, overflow 0, underflow 0.
REQ-031 Reset mid-playback SHALL discard all buffered samples; after reset_n rises, behaviour restarts from IDLE.

Verification
REQ-032 enable=1, push 8 samples 0x7FFF -> PLAY entered on 8th push count, playing=1, pwm_out high 255 of each 256 cycles.
REQ-033 In PLAY push 0x8000 then 0x0000 -> pwm_out duty 0 (constant low) for 1024 cycles, then 128/256 for 1024 cycles.
REQ-034 enable=1 but no pops, push 17 samples -> fifo_count=16, overflow=1; flags_clear pulse -> overflow=0.
REQ-035 PLAY with FIFO drained -> at next tick underflow=1, playing=0, state PRIME, pwm_out 50%.
REQ-036 FIFO full at tick with simultaneous sample_valid -> fifo_count stays 16, overflow stays 0, order preserved.
REQ-037 reset_n low mid-PLAY with 5 samples buffered -> fifo_count=0, pwm_out=0, playing=0 immediately, without clock edge.
